// File: rtl/nms_stream.sv
// Streaming Canny non-maximum suppression: one 3x3 magnitude window per beat, two-stage
// pipeline with full backpressure, border zeroing and per-frame edge statistics.
module nms_stream #(
    parameter int NBIT_INPUT  = 12,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter bit BORDER_ZERO = 1'b1,
    parameter int CNT_W       = 20
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [9*NBIT_INPUT-1:0] i_kernel,
    input  logic [1:0]              i_direction,
    input  logic                    i_sof,
    input  logic                    i_strict,
    input  logic [NBIT_INPUT-1:0]   i_low_thr,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [NBIT_INPUT-1:0]   o_mag,
    output logic                    o_frame_done,
    output logic [CNT_W-1:0]        o_edge_count
);

    localparam int N     = NBIT_INPUT;
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             en, accept, out_hs;
    logic [COL_W-1:0] col_q, col_d, pos_col;
    logic [ROW_W-1:0] row_q, row_d, pos_row;
    logic [N-1:0]     c_val, n0, n1;
    logic             cmp0, cmp1, thr_ok, border, last_px;

    logic             s1_valid_q, s1_thr_ok_q, s1_border_q, s1_last_q, s1_sof_q;
    logic [1:0]       s1_cmp_q;
    logic [N-1:0]     s1_c_q;
    logic             s1_keep;

    logic             valid_q, s2_last_q, s2_sof_q, frame_done_q;
    logic [N-1:0]     mag_q;
    logic [CNT_W-1:0] run_q, run_d, edge_q;
    logic             nz;

    // Handshake: a beat moves on either side only when valid and ready are both high at the
    // rising edge; both stages advance together on en, and o_ready never looks at i_valid.
    assign en      = !valid_q || i_ready;
    assign o_ready = en && !i_rst;
    assign accept  = i_valid && o_ready;
    assign out_hs  = valid_q && i_ready;

    assign c_val = i_kernel[4*N +: N];

    always_comb begin
        n0 = i_kernel[3*N +: N];
        n1 = i_kernel[5*N +: N];
        case (i_direction)
            2'b00: begin n0 = i_kernel[3*N +: N]; n1 = i_kernel[5*N +: N]; end
            2'b01: begin n0 = i_kernel[2*N +: N]; n1 = i_kernel[6*N +: N]; end
            2'b10: begin n0 = i_kernel[1*N +: N]; n1 = i_kernel[7*N +: N]; end
            default: begin n0 = i_kernel[0*N +: N]; n1 = i_kernel[8*N +: N]; end
        endcase
    end

    assign cmp0   = i_strict ? (c_val > n0) : (c_val >= n0);
    assign cmp1   = i_strict ? (c_val > n1) : (c_val >= n1);
    assign thr_ok = (c_val >= i_low_thr);

    // A sof beat is pixel (0,0) no matter where the counters were.
    always_comb begin
        pos_col = i_sof ? '0 : col_q;
        pos_row = i_sof ? '0 : row_q;
        if (pos_col == COL_LAST) begin
            col_d = '0;
            row_d = (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
        end else begin
            col_d = pos_col + 1'b1;
            row_d = pos_row;
        end
    end

    assign border  = BORDER_ZERO && (pos_col == '0 || pos_col == COL_LAST ||
                                     pos_row == '0 || pos_row == ROW_LAST);
    assign last_px = (pos_col == COL_LAST) && (pos_row == ROW_LAST);

    assign s1_keep = s1_valid_q && (&s1_cmp_q) && s1_thr_ok_q && !s1_border_q;

    assign nz    = |mag_q;
    assign run_d = s2_sof_q ? CNT_W'(nz) :
                   (nz && run_q != CNT_MAX) ? run_q + 1'b1 : run_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_q        <= '0;
            row_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_cmp_q     <= '0;
            s1_thr_ok_q  <= 1'b0;
            s1_border_q  <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_sof_q     <= 1'b0;
            s1_c_q       <= '0;
            valid_q      <= 1'b0;
            mag_q        <= '0;
            s2_last_q    <= 1'b0;
            s2_sof_q     <= 1'b0;
            frame_done_q <= 1'b0;
            run_q        <= '0;
            edge_q       <= '0;
        end else begin
            if (accept) begin
                col_q <= col_d;
                row_q <= row_d;
            end
            if (en) begin
                s1_valid_q  <= accept;
                s1_cmp_q    <= {cmp1, cmp0};
                s1_thr_ok_q <= thr_ok;
                s1_border_q <= border;
                s1_last_q   <= last_px;
                s1_sof_q    <= i_sof;
                s1_c_q      <= c_val;
                valid_q     <= s1_valid_q;
                mag_q       <= s1_keep ? s1_c_q : '0;
                s2_last_q   <= s1_valid_q && s1_last_q;
                s2_sof_q    <= s1_valid_q && s1_sof_q;
            end
            // Statistics move only on output handshakes so stalls never double count.
            frame_done_q <= out_hs && s2_last_q;
            if (out_hs) begin
                run_q <= run_d;
                if (s2_last_q) edge_q <= run_d;
            end
        end
    end

    assign o_valid      = valid_q;
    assign o_mag        = mag_q;
    assign o_frame_done = frame_done_q;
    assign o_edge_count = edge_q;

endmodule
